// File: rtl/tt_um_project_name.sv
// ---------------------------------------------------------------------------
// tt_um_project_name
//
// Tiny Tapeout user tile: programmable 8-bit up/down counter with a 4-bit
// prescaler, edge-triggered parallel load and a PWM/status output mode.
//
// Ports
//   clk      in   1  system clock, all state on the rising edge
//   rst_n    in   1  asynchronous active-low reset
//   ena      in   1  tile selected; 0 freezes every register
//   ui_in    in   8  [0] EN count enable, [1] DOWN, [2] LOAD, [3] MODE,
//                    [7:4] P prescale compare value
//   uo_out   out  8  MODE=0: count value
//                    MODE=1: {cnt[7:4], tick, wrap_s, wrap_p, pwm}
//   uio_in   in   8  parallel load value and live PWM duty compare value
//   uio_out  out  8  tied to 0
//   uio_oe   out  8  tied to 0 (all uio pins are inputs)
//
// ui_in and uio_in are used directly without synchronisers; the tile
// harness is expected to present them synchronous to clk.
// ---------------------------------------------------------------------------
module tt_um_project_name (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // -------------------------------------------------------------------------
  // Control field decode
  // -------------------------------------------------------------------------
  logic       w_en;
  logic       w_down;
  logic       w_load;
  logic       w_mode;
  logic [3:0] w_p;

  assign w_en   = ui_in[0];
  assign w_down = ui_in[1];
  assign w_load = ui_in[2];
  assign w_mode = ui_in[3];
  assign w_p    = ui_in[7:4];

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [7:0] r_cnt;
  logic [3:0] r_pre;
  logic       r_load_q;  // previous LOAD level, for rising-edge detect
  logic       r_wrap_p;  // one-cycle wrap pulse
  logic       r_wrap_s;  // sticky wrap flag, cleared only by a load

  // -------------------------------------------------------------------------
  // Combinational control
  // -------------------------------------------------------------------------
  logic       w_load_edge;
  logic       w_tick;
  logic       w_wrap;
  logic [7:0] w_cnt_next;
  logic       w_pwm;

  // Only the first cycle of a LOAD high level loads; holding it does nothing.
  assign w_load_edge = ena & w_load & ~r_load_q;

  // A >= compare (not ==) so that lowering P below the current prescaler
  // value ticks on the next enabled cycle instead of waiting for a 4-bit
  // wrap-around of the prescaler.
  assign w_tick = ena & w_en & (r_pre >= w_p);

  assign w_cnt_next = w_down ? (r_cnt - 8'd1) : (r_cnt + 8'd1);

  // Wrap condition depends only on direction and current count.
  assign w_wrap = w_down ? (r_cnt == 8'h00) : (r_cnt == 8'hFF);

  // Unsigned compare: duty 0 never asserts, duty FF asserts except at FF.
  assign w_pwm = (r_cnt < uio_in);

  // -------------------------------------------------------------------------
  // Sequential update. Load outranks a tick in the same cycle.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= 8'h00;
      r_pre    <= 4'h0;
      r_load_q <= 1'b0;
      r_wrap_p <= 1'b0;
      r_wrap_s <= 1'b0;
    end else if (ena) begin
      r_load_q <= w_load;
      if (w_load_edge) begin
        r_cnt    <= uio_in;
        r_pre    <= 4'h0;
        r_wrap_p <= 1'b0;
        r_wrap_s <= 1'b0;
      end else begin
        // Pulse lasts exactly the cycle after the wrapping tick.
        r_wrap_p <= w_tick & w_wrap;
        if (w_tick) begin
          r_cnt <= w_cnt_next;
          r_pre <= 4'h0;
          if (w_wrap) begin
            r_wrap_s <= 1'b1;
          end
        end else if (w_en) begin
          r_pre <= r_pre + 4'h1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    uo_out = r_cnt;
    if (w_mode) begin
      uo_out = {r_cnt[7:4], w_tick, r_wrap_s, r_wrap_p, w_pwm};
    end
  end

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_project_name.sv
// ---------------------------------------------------------------------------
// tb_tt_um_project_name
//
// Directed bench for the Tiny Tapeout counter tile. Inputs change 2 ns after
// a rising edge and outputs are sampled before the next edge.
// ---------------------------------------------------------------------------
module tb_tt_um_project_name;

  // -------------------------------------------------------------------------
  // Clock / reset block
  // -------------------------------------------------------------------------
  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int total;
  int bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  tt_um_project_name dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    #3;
    rst_n  = 1'b1;
    step();
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    #20;
    total++;
    if (uo_out !== 8'h00) begin
      bad++;
      $display("FAIL reset_mode0: got %h want %h", uo_out, 8'h00);
    end
    total++;
    if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
      bad++;
      $display("FAIL reset_uio: got out=%h oe=%h want 00/00", uio_out, uio_oe);
    end
    ui_in  = 8'h08;
    uio_in = 8'h05;
    settle();
    total++;
    if (uo_out !== 8'h01) begin
      bad++;
      $display("FAIL reset_mode1_pwm: got %h want %h", uo_out, 8'h01);
    end
    uio_in = 8'h00;
    settle();
    total++;
    if (uo_out !== 8'h00) begin
      bad++;
      $display("FAIL reset_mode1_nopwm: got %h want %h", uo_out, 8'h00);
    end
    ui_in = 8'h00;
    #3;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_count_up();
    logic [7:0] exp_v;
    do_reset();
    ui_in = 8'h01;
    settle();
    total++;
    if (uo_out !== 8'h00) begin
      bad++;
      $display("FAIL up_start: got %h want %h", uo_out, 8'h00);
    end
    for (int i = 1; i <= 300; i++) begin
      step();
      exp_v = i[7:0];
      total++;
      if (uo_out !== exp_v) begin
        bad++;
        $display("FAIL up_step%0d: got %h want %h", i, uo_out, exp_v);
      end
    end
    total++;
    if (uo_out !== 8'd44) begin
      bad++;
      $display("FAIL up_300: got %0d want 44", uo_out);
    end
    ui_in = 8'h00;
  endtask

  task automatic test_prescale();
    logic [7:0] exp_v;
    do_reset();
    ui_in = 8'h31;
    for (int e = 1; e <= 10; e++) begin
      step();
      exp_v = 8'(e / 4);
      total++;
      if (uo_out !== exp_v) begin
        bad++;
        $display("FAIL pre3_edge%0d: got %h want %h", e, uo_out, exp_v);
      end
    end
    // Hold with EN=0: count and prescaler (now 2) frozen.
    ui_in = 8'h30;
    for (int e = 0; e < 5; e++) step();
    total++;
    if (uo_out !== 8'h02) begin
      bad++;
      $display("FAIL pre3_hold: got %h want %h", uo_out, 8'h02);
    end
    ui_in = 8'h31;
    step();
    total++;
    if (uo_out !== 8'h02) begin
      bad++;
      $display("FAIL pre3_resume1: got %h want %h", uo_out, 8'h02);
    end
    // Prescaler is at 3 now: tick visible in the status word.
    ui_in = 8'h39;
    settle();
    total++;
    if (uo_out !== 8'h08) begin
      bad++;
      $display("FAIL pre3_tickbit: got %h want %h", uo_out, 8'h08);
    end
    step();
    total++;
    if (uo_out !== 8'h00) begin
      bad++;
      $display("FAIL pre3_after_tick: got %h want %h", uo_out, 8'h00);
    end
    ui_in = 8'h31;
    step();
    step();
    // Prescaler is 2; dropping P to 1 ticks on the very next edge.
    ui_in = 8'h11;
    settle();
    total++;
    if (uo_out !== 8'h03) begin
      bad++;
      $display("FAIL pre_lower_before: got %h want %h", uo_out, 8'h03);
    end
    step();
    total++;
    if (uo_out !== 8'h04) begin
      bad++;
      $display("FAIL pre_lower_tick: got %h want %h", uo_out, 8'h04);
    end
    ui_in = 8'h00;
  endtask

  task automatic test_wrap_up();
    logic [7:0] exp_seq [0:4];
    do_reset();
    uio_in = 8'hFE;
    ui_in  = 8'h04;
    step();
    ui_in = 8'h09;
    settle();
    total++;
    if (uo_out !== 8'hF8) begin
      bad++;
      $display("FAIL wrap_load_fe: got %h want %h", uo_out, 8'hF8);
    end
    // FF, 00 (wrap), 01, 02, 03
    exp_seq[0] = 8'hF8;
    exp_seq[1] = 8'h0F;
    exp_seq[2] = 8'h0D;
    exp_seq[3] = 8'h0D;
    exp_seq[4] = 8'h0D;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (uo_out !== exp_seq[i]) begin
        bad++;
        $display("FAIL wrap_up%0d: got %h want %h", i, uo_out, exp_seq[i]);
      end
    end
    // LOAD edge clears flags; holding LOAD does not reload.
    ui_in = 8'h0D;
    step();
    total++;
    if (uo_out !== 8'hF8) begin
      bad++;
      $display("FAIL wrap_reload: got %h want %h", uo_out, 8'hF8);
    end
    step();
    total++;
    if (uo_out !== 8'hF8) begin
      bad++;
      $display("FAIL wrap_hold_load: got %h want %h", uo_out, 8'hF8);
    end
    step();
    total++;
    if (uo_out !== 8'h0F) begin
      bad++;
      $display("FAIL wrap_again: got %h want %h", uo_out, 8'h0F);
    end
    ui_in = 8'h00;
  endtask

  task automatic test_down();
    do_reset();
    uio_in = 8'h01;
    ui_in  = 8'h04;
    step();
    ui_in = 8'h0B;
    settle();
    total++;
    if (uo_out !== 8'h08) begin
      bad++;
      $display("FAIL down_at1: got %h want %h", uo_out, 8'h08);
    end
    step();
    total++;
    if (uo_out !== 8'h09) begin
      bad++;
      $display("FAIL down_at0: got %h want %h", uo_out, 8'h09);
    end
    step();
    total++;
    if (uo_out !== 8'hFE) begin
      bad++;
      $display("FAIL down_wrap: got %h want %h", uo_out, 8'hFE);
    end
    step();
    total++;
    if (uo_out !== 8'hFC) begin
      bad++;
      $display("FAIL down_after_wrap: got %h want %h", uo_out, 8'hFC);
    end
    // Load and tick in the same cycle: load wins.
    uio_in = 8'h5A;
    ui_in  = 8'h07;
    step();
    total++;
    if (uo_out !== 8'h5A) begin
      bad++;
      $display("FAIL down_load_vs_tick: got %h want %h", uo_out, 8'h5A);
    end
    step();
    total++;
    if (uo_out !== 8'h59) begin
      bad++;
      $display("FAIL down_after_load: got %h want %h", uo_out, 8'h59);
    end
    ui_in = 8'h00;
  endtask

  task automatic test_pwm();
    int hi;
    logic [7:0] duty [0:2];
    int exp_hi [0:2];
    duty[0] = 8'h40; exp_hi[0] = 64;
    duty[1] = 8'h00; exp_hi[1] = 0;
    duty[2] = 8'hFF; exp_hi[2] = 255;
    do_reset();
    ui_in = 8'h09;
    for (int d = 0; d < 3; d++) begin
      uio_in = duty[d];
      settle();
      hi = 0;
      for (int c = 0; c < 256; c++) begin
        if (uo_out[0] === 1'b1) hi++;
        step();
      end
      total++;
      if (hi !== exp_hi[d]) begin
        bad++;
        $display("FAIL pwm_duty_%h: got %0d high cycles want %0d", duty[d], hi, exp_hi[d]);
      end
    end
    ui_in = 8'h00;
  endtask

  task automatic test_ena_and_reset();
    do_reset();
    ena   = 1'b0;
    ui_in = 8'h01;
    for (int i = 0; i < 5; i++) step();
    uio_in = 8'h77;
    ui_in  = 8'h05;
    step();
    ui_in = 8'h01;
    step();
    ui_in = 8'h05;
    step();
    total++;
    if (uo_out !== 8'h00) begin
      bad++;
      $display("FAIL ena_frozen: got %h want %h", uo_out, 8'h00);
    end
    ena = 1'b1;
    step();
    total++;
    if (uo_out !== 8'h77) begin
      bad++;
      $display("FAIL ena_load: got %h want %h", uo_out, 8'h77);
    end
    ui_in = 8'h01;
    step();
    step();
    step();
    total++;
    if (uo_out !== 8'h7A) begin
      bad++;
      $display("FAIL ena_count: got %h want %h", uo_out, 8'h7A);
    end
    // Asynchronous reset mid-count, no clock edge in between.
    rst_n = 1'b0;
    #1;
    total++;
    if (uo_out !== 8'h00) begin
      bad++;
      $display("FAIL async_reset: got %h want %h", uo_out, 8'h00);
    end
    #3;
    rst_n = 1'b1;
    step();
    total++;
    if (uo_out !== 8'h01) begin
      bad++;
      $display("FAIL resume_after_reset: got %h want %h", uo_out, 8'h01);
    end
    ui_in = 8'h00;
  endtask

  // -------------------------------------------------------------------------
  // Sequence and final report
  // -------------------------------------------------------------------------
  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    test_reset();
    test_count_up();
    test_prescale();
    test_wrap_up();
    test_down();
    test_pwm();
    test_ena_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
